// File: rtl/vliw_hazard_pkg.sv
// Shared constants and helpers for the VLIW hazard unit and its register scoreboard.
package vliw_hazard_pkg;

  localparam int NREG_DEF     = 32;
  localparam int REG_IDX_W    = $clog2(NREG_DEF);
  localparam int ALU_LAT_DEF  = 1;
  localparam int LOAD_LAT_DEF = 2;
  localparam int EX_SLACK_DEF = 1;

  // Counter width: wide enough to hold the longest writer latency.
  function automatic int calc_cw(input int alu_lat, input int load_lat);
    int max_lat;
    max_lat = (alu_lat > load_lat) ? alu_lat : load_lat;
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/vliw_hazard_unit_reg_scoreboard.sv
// Per-register countdown scoreboard: issuing writers load a latency, everything else
// counts down to zero. Register 0 never holds a pending write.
module reg_scoreboard
  import vliw_hazard_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int NREG     = NREG_DEF,
  parameter int RW       = $clog2(NREG),
  parameter int ALU_LAT  = ALU_LAT_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int CW       = calc_cw(ALU_LAT, LOAD_LAT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue,
  input  logic [LANES*RW-1:0] rd,
  input  logic [LANES-1:0]    regwrite,
  input  logic [LANES-1:0]    memread,
  input  logic [LANES*RW-1:0] rs1,
  input  logic [LANES*RW-1:0] rs2,
  output logic [LANES*CW-1:0] rs1_cnt,
  output logic [LANES*CW-1:0] rs2_cnt
);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];

  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - CW'(1);
      // Ascending lane order lets the highest-index writer of a register win.
      for (int l = 0; l < LANES; l++) begin
        if (issue && regwrite[l] && (rd[l*RW +: RW] == RW'(r))) begin
          cnt_d[r] = memread[l] ? CW'(LOAD_LAT) : CW'(ALU_LAT);
        end
      end
    end
    cnt_d[0] = '0;
  end

  // NOTE: the counter array is reset because stale counts would stall the pipe after reset;
  // state uses non-blocking assignments, combinational logic uses blocking ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      rs1_cnt[l*CW +: CW] = cnt_q[rs1[l*RW +: RW]];
      rs2_cnt[l*CW +: CW] = cnt_q[rs2[l*RW +: RW]];
    end
  end

endmodule

// File: rtl/vliw_hazard_unit.sv
// Decode-stage hazard unit: scoreboard-based stall/bubble generation, branch/jump
// redirect and a saturating stall-cycle counter.
module vliw_hazard_unit
  import vliw_hazard_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int NREG     = NREG_DEF,
  parameter int RW       = $clog2(NREG),
  parameter int ALU_LAT  = ALU_LAT_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int EX_SLACK = EX_SLACK_DEF,
  parameter int CW       = calc_cw(ALU_LAT, LOAD_LAT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic                kill,
  input  logic [LANES*RW-1:0] id_rs1,
  input  logic [LANES*RW-1:0] id_rs2,
  input  logic [LANES*RW-1:0] id_rd,
  input  logic [LANES-1:0]    id_use_rs1,
  input  logic [LANES-1:0]    id_use_rs2,
  input  logic [LANES-1:0]    id_regwrite,
  input  logic [LANES-1:0]    id_memread,
  input  logic                id_branch,
  input  logic                id_jump,
  input  logic                br_taken,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                ctrl_flush,
  output logic                branch_pc_src,
  output logic                jump_pc_src,
  output logic                ifid_flush,
  output logic [31:0]         stall_cycles
);

  logic [LANES*CW-1:0] rs1_cnt;
  logic [LANES*CW-1:0] rs2_cnt;
  logic                hazard;
  logic                stall;
  logic                issue;
  logic [31:0]         stall_cycles_q;
  logic [31:0]         stall_cycles_d;

  reg_scoreboard #(
    .LANES    (LANES),
    .NREG     (NREG),
    .RW       (RW),
    .ALU_LAT  (ALU_LAT),
    .LOAD_LAT (LOAD_LAT),
    .CW       (CW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .rd       (id_rd),
    .regwrite (id_regwrite),
    .memread  (id_memread),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_cnt  (rs1_cnt),
    .rs2_cnt  (rs2_cnt)
  );

  // Branch operands are compared in ID without forwarding, so any pending write blocks them.
  function automatic logic src_hazard(input logic use_src, input logic [RW-1:0] idx,
                                      input logic [CW-1:0] cnt, input logic in_id);
    if (!use_src || idx == '0) return 1'b0;
    if (in_id) return cnt != '0;
    return int'(cnt) > EX_SLACK;
  endfunction

  always_comb begin
    hazard = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (src_hazard(id_use_rs1[l], id_rs1[l*RW +: RW], rs1_cnt[l*CW +: CW], (l == 0) && id_branch) ||
          src_hazard(id_use_rs2[l], id_rs2[l*RW +: RW], rs2_cnt[l*CW +: CW], (l == 0) && id_branch)) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    stall         = id_valid && !kill && hazard;
    issue         = id_valid && !kill && !stall && !reset;
    pc_write      = !stall;
    ifid_write    = !stall;
    ctrl_flush    = stall;
    branch_pc_src = issue && id_branch && br_taken;
    jump_pc_src   = issue && id_jump && !branch_pc_src;
    ifid_flush    = branch_pc_src || jump_pc_src;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/vliw_hazard_unit.md
# vliw_hazard_unit

Parametrised, scoreboard-based hazard unit for the VLIW decode stage: it replaces the separate load-use, branch-data and branch-control checks with one block. A per-register countdown scoreboard covers any number of issue lanes and configurable ALU and load latencies. From the scoreboard it generates the stall, bubble, redirect and IF/ID-flush controls, and it keeps a saturating stall-cycle performance counter. It sits beside the ID stage and drives the PC, the IF/ID register and the ID/EX control mux.

## Interface
- LANES, 2: issue lanes per bundle.
- NREG, 32: architectural registers; register 0 is hard-wired zero.
- RW, $clog2(NREG): register index width.
- ALU_LAT, 1: scoreboard load value for non-load writers.
- LOAD_LAT, 2: scoreboard load value for loads.
- EX_SLACK, 1: highest count an EX-stage consumer tolerates, using forwarding.
- CW, $clog2(max(ALU_LAT,LOAD_LAT)+1): counter width.

Ports:
- clk  in  1  clock; everything is synchronous to the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  a bundle is present in ID.
- kill  in  1  squash the ID bundle (exception); it does not issue.
- id_rs1, id_rs2, id_rd  in  LANES*RW  per-lane register indices, lane l at [l*RW +: RW].
- id_use_rs1, id_use_rs2  in  LANES  source actually read.
- id_regwrite, id_memread  in  LANES  lane writes rd / lane is a load.
- id_branch  in  1  lane 0 holds a conditional branch resolved in ID.
- id_jump  in  1  lane 0 holds a jump.
- br_taken  in  1  ID comparator result.
- pc_write, ifid_write  out  1  enable the PC and the IF/ID register.
- ctrl_flush  out  1  insert a bubble into ID/EX.
- branch_pc_src, jump_pc_src  out  1  PC redirect selects.
- ifid_flush  out  1  squash the fetched instruction.
- stall_cycles  out  32  saturating count of stall cycles.

## Operation
- Scoreboard: cnt[r] is a CW-bit counter for each r in 1..NREG-1; cnt[0] is constant 0.
- A source s is checked only when its use bit is set and s != 0.
- Normal source (EX consumer) hazards when cnt[s] > EX_SLACK.
- Branch source (lane 0 with id_branch) hazards when cnt[s] > 0, because there is no forwarding into ID.
- stall = id_valid & !kill & (any lane has a hazarding source).
- issue = id_valid & !kill & !stall & !reset.
- Counter update, every cycle, per register:
  - If some issuing lane writes r (id_regwrite set, rd = r, rd != 0), cnt[r] <= (id_memread ? LOAD_LAT : ALU_LAT).
  - When several lanes write the same rd, the highest-index lane's latency wins.
  - Otherwise, cnt[r] <= cnt[r] - 1, saturating at 0.
  - A set always overrides the decrement in the same cycle.
- Intra-bundle reads of a sibling lane's rd are not hazards; they read the old value.
- pc_write = ifid_write = !stall; ctrl_flush = stall.
- Redirect, evaluated only on issue:
  - branch_pc_src = issue & id_branch & br_taken.
  - jump_pc_src = issue & id_jump & !branch_pc_src; a taken branch has priority over a jump.
  - ifid_flush = branch_pc_src | jump_pc_src.
  - A branch or jump that is stalled does not redirect.
- kill: forces stall = 0 and issue = 0. Counters keep decrementing, because in-flight writers still complete.
- stall_cycles increments on every cycle with stall = 1 and holds at 32'hFFFF_FFFF.

## Timing
- All outputs except stall_cycles are combinational from the inputs and the scoreboard, with zero latency.
- The scoreboard and stall_cycles are registered.
- Reset, applied at the next edge: all cnt = 0 and stall_cycles = 0.
  - While reset is high, issue = 0. With cnt = 0 this gives pc_write = 1, ifid_write = 1, ctrl_flush = 0, and all redirects = 0.
- Asserting reset mid-stall clears the scoreboard; the stall releases on the cycle after the reset edge.
- Load issued at t: a dependent ALU instruction stalls at t+1 and issues at t+2. A dependent branch stalls at t+1 and t+2, and issues at t+3.
- ALU instruction issued at t: a dependent ALU instruction issues at t+1 with no stall. A dependent branch stalls one cycle.

## Structure
- Shared package vliw_hazard_pkg holds:
  - the default latency constants (ALU_LAT, LOAD_LAT, EX_SLACK);
  - the register-index width;
  - the helper that computes CW.
- Sub-module reg_scoreboard contains the counter array, the set/decrement logic with highest-lane priority, and the read ports. The top level contains the hazard compare, the stall/redirect logic and stall_cycles.

## Test plan
- Load rd=5 issued in lane 0, then add rs1=5 in lane 1 → exactly one cycle with pc_write = 0 and ctrl_flush = 1; issue in the following cycle; stall_cycles = 1.
- ALU writes rd=7, then a branch on rs2=7 with br_taken = 1 → one stall; then branch_pc_src = 1 and ifid_flush = 1 for a single cycle.
- Load rd=3, then a branch on rs1=3 → two stall cycles, then issue; branch_pc_src only in the issue cycle.
- Lane 0 load rd=9 and lane 1 ALU rd=9 in the same bundle, then a consumer of 9 → cnt[9] = 1, so there is no stall.
- Consumer of rd=0 after a write to 0 → never stalls. id_jump with id_branch and br_taken all set → branch_pc_src = 1 and jump_pc_src = 0.
- Reset asserted mid-load-stall → stall clears the cycle after the reset edge and stall_cycles reads 0. Also drive a 2^32+ stall run (force the counter near its top) → stall_cycles saturates at 32'hFFFF_FFFF.
